// File: rtl/jkff_upcounter_pkg.sv
// Shared constants for the JK flip-flop up-counter: JK mode encodings and default width.
package jkff_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    CLR  = 2'b01,
    SET  = 2'b10,
    TOG  = 2'b11
  } jk_mode_e;

  localparam int unsigned JKFF_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/jkff_upcounter_if.sv
// Count-output bundle for jkff_upcounter; tc exists only with JKFF_UPCOUNTER_TC_EN.
interface jkff_upcounter_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] q;
`ifdef JKFF_UPCOUNTER_TC_EN
  logic             tc;

  modport master (output q, output tc);
  modport slave  (input  q, input  tc);
`else
  modport master (output q);
  modport slave  (input  q);
`endif
endinterface

// File: rtl/jkff_upcounter_jk_ff.sv
// Single JK flip-flop with asynchronous active-high clear.
module jk_ff
  import jkff_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  logic     q_q;
  logic     q_d;
  jk_mode_e mode;

  assign mode = jk_mode_e'({j, k});

  always_comb begin
    q_d = q_q;
    case (mode)
      HOLD:    q_d = q_q;
      CLR:     q_d = 1'b0;
      SET:     q_d = 1'b1;
      TOG:     q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q  = q_q;
  assign qn = ~q_q;

endmodule

// File: rtl/jkff_upcounter.sv
// Synchronous binary up-counter built from WIDTH JK flip-flops on one clock.
// Optional terminal-count output tc enabled by macro JKFF_UPCOUNTER_TC_EN.
module jkff_upcounter
  import jkff_pkg::*;
#(
  parameter int unsigned WIDTH = JKFF_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
`ifdef JKFF_UPCOUNTER_TC_EN
  ,
  output logic             tc
`endif
);

  // t[i] is the toggle enable of stage i: high when every lower bit is one.
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] qn_unused;

  assign t[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign t[i] = t[i-1] & q[i-1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    jk_ff u_ff (
      .clk   (clk),
      .reset (reset),
      .j     (t[i]),
      .k     (t[i]),
      .q     (q[i]),
      .qn    (qn_unused[i])
    );
  end

`ifdef JKFF_UPCOUNTER_TC_EN
  assign tc = (&q) & ~reset;
`endif

endmodule

// File: tb/tb_jkff_upcounter.sv
// Self-checking bench for jkff_upcounter: directed reset/count/wrap steps then random reset traffic.
module tb_jkff_upcounter;

  localparam int unsigned W   = 4;
  localparam int unsigned MOD = 1 << W;

  logic clk;
  logic reset;

  jkff_upcounter_if #(.WIDTH(W)) cnt_if ();

  jkff_upcounter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (cnt_if.q)
`ifdef JKFF_UPCOUNTER_TC_EN
    ,
    .tc    (cnt_if.tc)
`endif
  );

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned exp_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk(tag, {{(32-W){1'b0}}, cnt_if.q}, exp_cnt);
`ifdef JKFF_UPCOUNTER_TC_EN
    chk({tag, "_tc"}, {31'd0, cnt_if.tc}, {31'd0, (exp_cnt == MOD - 1) && !reset});
`endif
  endtask

  // One rising edge; the model counts unless reset was high at the edge.
  task automatic step(input string tag);
    logic rs;
    rs = reset;
    @(posedge clk);
    #1;
    exp_cnt = rs ? 0 : (exp_cnt + 1) % MOD;
    check_state(tag);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = 0;
    reset   = 1'b1;

    #1;
    check_state("reset_initial");
    step("reset_hold_edge1");
    step("reset_hold_edge2");

    #2 reset = 1'b0;
    #1 check_state("released_idle");
    for (int i = 0; i < 15; i++) step("count_up");
    chk("reached_all_ones", {{(32-W){1'b0}}, cnt_if.q}, MOD - 1);
    step("wrap_to_zero");
    step("after_wrap");

    for (int i = 0; i < 5; i++) step("count_to_six");
    chk("at_six", {{(32-W){1'b0}}, cnt_if.q}, 32'd6);
    #2 reset = 1'b1;
    exp_cnt = 0;
    #1 check_state("async_clear");
    step("reset_hold_a");
    step("reset_hold_b");

    // Release on the edge itself: the flop sees reset still high at this edge.
    @(posedge clk);
    reset <= 1'b0;
    #1;
    exp_cnt = 0;
    check_state("coincident_release");
    step("first_after_release");

    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      r = $urandom_range(0, 15);
      if (r == 0 && !reset) begin
        #2 reset = 1'b1;
        exp_cnt = 0;
        #1 check_state("rand_async_clear");
      end else if (r < 4 && reset) begin
        #2 reset = 1'b0;
      end
      step("rand_step");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
